neuron_acc: RTL
===============

NEURON_ACC -- requirements
Module: neuron_acc

Interface
REQ-001 Parameter IN_W, default 20: signed width of each MAC product input.
REQ-002 Parameter B_W, default 8: signed width of the bias input.
REQ-003 Parameter ACC_W, default 22: signed accumulator and output width; ACC_W >= IN_W and ACC_W >= B_W.
REQ-004 Parameter N_IN, default 784: products summed per neuron; N_IN >= 1.
REQ-005 Parameter RELU, default 1: 1 = apply ReLU at the output; 0 = pass the raw sum.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  asynchronous active-high reset.
REQ-009 start  input  1  begin a new neuron sum; sampled only in IDLE, or in DONE together with out_ready.
REQ-010 bias  input  B_W  signed bias; sampled on an accepted start.
REQ-011 mac_valid  input  1  mac_in carries a valid product this cycle.
REQ-012 mac_in  input  IN_W  signed product term.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_valid  output  1  acc_out holds the final result.
REQ-015 acc_out  output  ACC_W  signed neuron result; registered.
REQ-016 busy  output  1  high in ACCUM and DONE.
REQ-017 ovf  output  1  sticky saturation flag for the current neuron.

Function
REQ-018 States SHALL be IDLE, ACCUM and DONE, with a $clog2(N_IN)-bit (min 1) product counter cnt.
REQ-019 IDLE + start: acc <= sign-extended bias, cnt <= 0, ovf <= 0, next state ACCUM; latency is 1 cycle.
REQ-020 ACCUM + mac_valid: acc <= sat(acc + sext(mac_in)), cnt <= cnt+1; cycles with mac_valid low SHALL hold acc and cnt.
REQ-021 Saturation: a sum above 2^(ACC_W-1)-1 SHALL clamp to that value, and a sum below -2^(ACC_W-1) SHALL clamp to that value; ovf SHALL be set and held until the next accepted start.
REQ-022 ACCUM + mac_valid with cnt == N_IN-1 SHALL add the final term and move to DONE; out_valid SHALL rise in the same cycle the state becomes DONE.
REQ-023 acc_out in DONE = (RELU && acc<0) ? 0 : acc; acc_out SHALL be stable while out_valid is high.
REQ-024 DONE + out_ready low: hold state, acc_out and out_valid.
REQ-025 DONE + out_ready high + start low: go to IDLE next cycle with out_valid 0.
REQ-026 DONE + out_ready high + start high: hand off the result and load the new bias in the same edge; go to ACCUM with no idle bubble.
REQ-027 start in ACCUM SHALL be ignored; mac_valid in IDLE or DONE SHALL be ignored.
REQ-028 acc_out SHALL retain the last delivered value in IDLE; it SHALL update only on entry to DONE.
REQ-029 busy SHALL be high exactly when state is ACCUM or DONE.

Reset
REQ-030 reset high SHALL immediately force state IDLE, acc 0, cnt 0, acc_out 0, out_valid 0, busy 0, ovf 0, independent of clk.
REQ-031 reset asserted mid-ACCUM or in DONE SHALL discard the partial or pending result; the first start after release SHALL behave as from power-up.

Verification (N_IN=4, IN_W=20, B_W=8, ACC_W=22 unless noted)
REQ-032 bias=5, start, then mac_in 10,20,30,40 on consecutive valid cycles -> out_valid 1 cycle after the 4th term, acc_out=105, ovf=0.
REQ-033 RELU=1, bias=-128, mac_in -1000,0,0,0 -> acc_out=0; RELU=0 with the same stimulus -> acc_out=-1128.
REQ-034 bias=0, four terms of 524287 with ACC_W=20 -> acc_out=524287, ovf=1; the next start clears ovf.
REQ-035 mac_valid gapped (1,0,0,1,1,0,1) with terms 1,2,3,4 -> acc_out=10 on the 4th valid term only; out_ready held low 5 cycles -> acc_out and out_valid stable throughout.
REQ-036 In DONE, out_ready=1 with start=1 and bias=3 -> next cycle ACCUM, acc=3, out_valid=0; start pulsed mid-ACCUM -> no effect on the sum.
REQ-037 reset pulsed after the 2nd term -> all outputs 0 asynchronously; the following run with bias=1 and terms 1,1,1,1 -> acc_out=5.

Source files
------------

// File: rtl/neuron_acc.sv
// Neuron accumulator: a bias plus N_IN signed product terms are summed with saturation.
// An optional ReLU is applied and the result is held behind an out_valid/out_ready handshake.
module neuron_acc #(
  parameter int IN_W  = 20,
  parameter int B_W   = 8,
  parameter int ACC_W = 22,
  parameter int N_IN  = 784,
  parameter int RELU  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [B_W-1:0]   bias,
  input  logic                    mac_valid,
  input  logic signed [IN_W-1:0]  mac_in,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    busy,
  output logic                    ovf
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t                  state, state_nx;
  logic signed [ACC_W-1:0] acc, acc_nx;
  logic signed [ACC_W-1:0] acc_out_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic                    ovf_nx;

  logic signed [ACC_W:0]   sum;
  logic                    sat_hi, sat_lo;
  logic signed [ACC_W-1:0] acc_sat;
  logic signed [ACC_W-1:0] result;
  logic                    accept;

  // One guard bit is enough: a single add of two ACC_W-wide signed values cannot wrap ACC_W+1 bits.
  always_comb begin
    sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(mac_in);
    sat_hi  = !sum[ACC_W] &&  sum[ACC_W-1];
    sat_lo  =  sum[ACC_W] && !sum[ACC_W-1];
    acc_sat = sum[ACC_W-1:0];
    if (sat_hi) acc_sat = ACC_MAX;
    if (sat_lo) acc_sat = ACC_MIN;
    result  = ((RELU != 0) && acc_sat[ACC_W-1]) ? '0 : acc_sat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    cnt_nx     = cnt;
    ovf_nx     = ovf;
    acc_out_nx = acc_out;
    accept     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ACCUM;
        end
      end
      ACCUM: begin
        if (mac_valid) begin
          acc_nx = acc_sat;
          cnt_nx = cnt + CNT_W'(1);
          ovf_nx = ovf | sat_hi | sat_lo;
          if (cnt == LAST_CNT) begin
            cnt_nx     = '0;
            acc_out_nx = result;
            state_nx   = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          // A start alongside out_ready hands off and restarts on the same edge.
          accept   = start;
          state_nx = start ? ACCUM : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (accept) begin
      acc_nx = ACC_W'(bias);
      cnt_nx = '0;
      ovf_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      acc_out <= '0;
    end else begin
      acc     <= acc_nx;
      cnt     <= cnt_nx;
      ovf     <= ovf_nx;
      acc_out <= acc_out_nx;
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
